lb_burst_master: RTL and testbench

- Local-bus master that turns host burst commands (write or read, base address, beat count) into single-cycle localbus strobes.
- Generates the delayed read-enable, read-last and read-address pipelines that the BRAM controller uses for fixed-latency read muxing.
- Collects returned read data into a response FIFO with backpressure.
- Sits between the host bridge (AXI/Ethernet packet decoder) and the BRAM/register controllers on the localbus.

---
 rtl/lb_pkg.sv | 17 +
 rtl/lb_burst_master_if.sv | 62 ++++++
 rtl/lb_burst_master_resp_fifo.sv | 59 +++++
 rtl/lb_burst_master.sv | 147 ++++++++++++++
 tb/tb_lb_burst_master.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lb_pkg.sv
// rtl/lb_pkg.sv - shared FSM state type and default widths for the localbus burst master
package lb_pkg;

    localparam int LB_ADDR_WIDTH = 24;
    localparam int LB_DATA_WIDTH = 32;
    localparam int LB_LEN_WIDTH  = 12;
    localparam int LB_PIPE_DEPTH = 16;
    localparam int LB_RESP_DEPTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } lb_state_t;

endpackage

// File: rtl/lb_burst_master_if.sv
// rtl/lb_burst_master_if.sv - host command/data/response and localbus signal bundle
interface lb_burst_master_if
    import lb_pkg::*;
#(
    parameter int ADDR_WIDTH = LB_ADDR_WIDTH,
    parameter int DATA_WIDTH = LB_DATA_WIDTH,
    parameter int LEN_WIDTH  = LB_LEN_WIDTH,
    parameter int PIPE_DEPTH = LB_PIPE_DEPTH
);

    logic                             cmd_valid;
    logic                             cmd_ready;
    logic                             cmd_write;
    logic [ADDR_WIDTH-1:0]            cmd_addr;
    logic [LEN_WIDTH-1:0]             cmd_len;

    logic                             wr_valid;
    logic                             wr_ready;
    logic [DATA_WIDTH-1:0]            wr_data;

    logic                             rsp_valid;
    logic                             rsp_ready;
    logic [DATA_WIDTH-1:0]            rsp_data;
    logic                             rsp_last;

    logic                             lb_wren;
    logic [ADDR_WIDTH-1:0]            lb_waddr;
    logic [DATA_WIDTH-1:0]            lb_wdata;
    logic                             lb_rden;
    logic [ADDR_WIDTH-1:0]            lb_raddr;
    logic [PIPE_DEPTH-1:0]            lb_rden16;
    logic [PIPE_DEPTH-1:0]            lb_rdenlast16;
    logic [PIPE_DEPTH*ADDR_WIDTH-1:0] lb_raddr16;
    logic [DATA_WIDTH-1:0]            lb_rdata;
    logic                             lb_rvalid;
    logic                             lb_rvalidlast;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready,
        input  wr_valid, wr_data,
        output wr_ready,
        output rsp_valid, rsp_data, rsp_last,
        input  rsp_ready,
        output lb_wren, lb_waddr, lb_wdata,
        output lb_rden, lb_raddr, lb_rden16, lb_rdenlast16, lb_raddr16,
        input  lb_rdata, lb_rvalid, lb_rvalidlast
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready,
        output wr_valid, wr_data,
        input  wr_ready,
        input  rsp_valid, rsp_data, rsp_last,
        output rsp_ready,
        input  lb_wren, lb_waddr, lb_wdata,
        input  lb_rden, lb_raddr, lb_rden16, lb_rdenlast16, lb_raddr16,
        output lb_rdata, lb_rvalid, lb_rvalidlast
    );

endinterface

// File: rtl/lb_burst_master_resp_fifo.sv
// rtl/lb_burst_master_resp_fifo.sv - synchronous first-word-fall-through response FIFO with occupancy count
module lb_resp_fifo
    import lb_pkg::*;
#(
    parameter int WIDTH = LB_DATA_WIDTH + 1,
    parameter int DEPTH = LB_RESP_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && (cnt != '0);
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign valid = (cnt != '0);
    assign head  = valid ? mem[rd_ptr] : '0;
    assign count = cnt;

endmodule

// File: rtl/lb_burst_master.sv
// rtl/lb_burst_master.sv - turns host burst commands into localbus strobes and collects read returns
module lb_burst_master
    import lb_pkg::*;
#(
    parameter int ADDR_WIDTH = LB_ADDR_WIDTH,
    parameter int DATA_WIDTH = LB_DATA_WIDTH,
    parameter int LEN_WIDTH  = LB_LEN_WIDTH,
    parameter int PIPE_DEPTH = LB_PIPE_DEPTH,
    parameter int RESP_DEPTH = LB_RESP_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    lb_burst_master_if.master bus,
    output logic              busy,
    output logic              err_spurious
);

    localparam int CNT_W   = $clog2(RESP_DEPTH) + 1;
    localparam int GUARD_W = $clog2(2 * PIPE_DEPTH + 1);
    localparam logic [GUARD_W-1:0] GUARD_END = GUARD_W'(2 * PIPE_DEPTH);
    localparam logic [CNT_W:0]     CREDIT    = (CNT_W + 1)'(RESP_DEPTH);

    lb_state_t                        state;
    logic [ADDR_WIDTH-1:0]            addr;
    logic [LEN_WIDTH-1:0]             remaining;
    logic [CNT_W-1:0]                 outstanding;
    logic [CNT_W-1:0]                 fifo_count;
    logic [GUARD_W-1:0]               guard_cnt;

    logic                             wren_q;
    logic [ADDR_WIDTH-1:0]            waddr_q;
    logic [DATA_WIDTH-1:0]            wdata_q;
    logic [ADDR_WIDTH-1:0]            raddr_q;
    logic [PIPE_DEPTH-1:0]            rden_pipe;
    logic [PIPE_DEPTH-1:0]            rdenlast_pipe;
    logic [PIPE_DEPTH*ADDR_WIDTH-1:0] raddr_pipe;

    logic                             credit_ok;
    logic                             issue;
    logic                             wr_beat;
    logic                             ret_ok;
    logic                             spurious;
    logic [DATA_WIDTH:0]              fifo_head;

    // Reads already in flight plus words parked in the FIFO may never exceed its depth.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < CREDIT;
    assign issue     = (state == ST_READ) && credit_ok;
    assign wr_beat   = (state == ST_WRITE) && bus.wr_valid;
    assign ret_ok    = bus.lb_rvalid && (outstanding != '0);
    // Returns from a burst abandoned by reset may still trickle in; stay quiet until they have flushed.
    assign spurious  = bus.lb_rvalid && (outstanding == '0) && (guard_cnt == GUARD_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        addr      <= bus.cmd_addr;
                        remaining <= bus.cmd_len;
                        state     <= bus.cmd_write ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (bus.wr_valid) begin
                        addr      <= addr + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == '0) state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (credit_ok) begin
                        addr      <= addr + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == '0) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (outstanding == '0) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wren_q        <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            raddr_q       <= '0;
            rden_pipe     <= '0;
            rdenlast_pipe <= '0;
            raddr_pipe    <= '0;
            outstanding   <= '0;
            err_spurious  <= 1'b0;
            guard_cnt     <= '0;
        end else begin
            wren_q        <= wr_beat;
            waddr_q       <= wr_beat ? addr : '0;
            wdata_q       <= wr_beat ? bus.wr_data : '0;
            raddr_q       <= issue ? addr : '0;
            rden_pipe     <= {rden_pipe[PIPE_DEPTH-2:0], issue};
            rdenlast_pipe <= {rdenlast_pipe[PIPE_DEPTH-2:0], issue && (remaining == '0)};
            raddr_pipe    <= {raddr_pipe[(PIPE_DEPTH-1)*ADDR_WIDTH-1:0], raddr_q};
            case ({issue, ret_ok})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (spurious) err_spurious <= 1'b1;
            if (guard_cnt != GUARD_END) guard_cnt <= guard_cnt + GUARD_W'(1);
        end
    end

    lb_resp_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ret_ok),
        .push_data ({bus.lb_rvalidlast, bus.lb_rdata}),
        .pop       (bus.rsp_ready),
        .head      (fifo_head),
        .valid     (bus.rsp_valid),
        .count     (fifo_count)
    );

    assign bus.rsp_data      = fifo_head[DATA_WIDTH-1:0];
    assign bus.rsp_last      = fifo_head[DATA_WIDTH];
    assign bus.cmd_ready     = (state == ST_IDLE);
    assign bus.wr_ready      = (state == ST_WRITE);
    assign bus.lb_wren       = wren_q;
    assign bus.lb_waddr      = waddr_q;
    assign bus.lb_wdata      = wdata_q;
    assign bus.lb_rden       = rden_pipe[0];
    assign bus.lb_raddr      = raddr_q;
    assign bus.lb_rden16     = rden_pipe;
    assign bus.lb_rdenlast16 = rdenlast_pipe;
    assign bus.lb_raddr16    = raddr_pipe;
    assign busy              = (state != ST_IDLE) || (outstanding != '0);

endmodule

// File: tb/tb_lb_burst_master.sv
// tb/tb_lb_burst_master.sv - directed plus randomized bursts checked against an address-arithmetic model
module tb_lb_burst_master;
    import lb_pkg::*;

    localparam int AW = LB_ADDR_WIDTH;
    localparam int DW = LB_DATA_WIDTH;
    localparam int LW = LB_LEN_WIDTH;
    localparam int PD = LB_PIPE_DEPTH;
    localparam int RD = LB_RESP_DEPTH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic err_spurious;
    logic inj_rvalid = 1'b0;
    int   rdy_mode = 0;

    lb_burst_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .PIPE_DEPTH(PD)) bus ();

    lb_burst_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .PIPE_DEPTH(PD), .RESP_DEPTH(RD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .busy         (busy),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    // BRAM stand-in: returns data = word address when the read enable reaches tap 5
    assign bus.lb_rvalid     = bus.lb_rden16[5] | inj_rvalid;
    assign bus.lb_rvalidlast = bus.lb_rdenlast16[5];
    assign bus.lb_rdata      = inj_rvalid ? 32'hDEAD_BEEF : DW'(bus.lb_raddr16[4*AW +: AW]);

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [AW-1:0] wr_a[$];
    logic [DW-1:0] wr_d[$];
    int            wr_c[$];
    logic [AW-1:0] iss_a[$];
    logic          iss_l[$];
    logic [DW-1:0] rsp_d[$];
    logic          rsp_l[$];
    logic [DW-1:0] exp_wd[$];
    logic [AW-1:0] raddr_ring[8];
    logic          rden_ring[8];
    int            cyc = 0;
    int            since_rst = 0;
    int            pipe_errs = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) since_rst = 0;
            else since_rst++;
            if (bus.lb_wren) begin
                wr_a.push_back(bus.lb_waddr);
                wr_d.push_back(bus.lb_wdata);
                wr_c.push_back(cyc);
            end
            if (bus.lb_rden) begin
                iss_a.push_back(bus.lb_raddr);
                iss_l.push_back(bus.lb_rdenlast16[0]);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_d.push_back(bus.rsp_data);
                rsp_l.push_back(bus.rsp_last);
            end
            if (since_rst > 6) begin
                if (bus.lb_raddr16[4*AW +: AW] !== raddr_ring[(cyc-5)%8] ||
                    bus.lb_rden16[5] !== rden_ring[(cyc-5)%8]) pipe_errs++;
            end
            raddr_ring[cyc%8] = bus.lb_raddr;
            rden_ring[cyc%8]  = bus.lb_rden;
        end
    end

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = 1'($urandom_range(0, 1));
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_a.delete(); wr_d.delete(); wr_c.delete();
        iss_a.delete(); iss_l.delete();
        rsp_d.delete(); rsp_l.delete();
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] len);
        int t = 0;
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_len = len;
        while (t < 200) begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            t++;
        end
        to_drive();
        bus.cmd_valid = 1'b0;
        chk("cmd_accept_timeout", 64'(t >= 200), 0);
    endtask

    task automatic push_beats(input int gap_at, input bit rand_gaps);
        int  i = 0;
        int  t = 0;
        bit  gapped = 0;
        bit  take;
        while (i < exp_wd.size() && t < 2000) begin
            if ((i == gap_at && !gapped) || (rand_gaps && $urandom_range(0, 3) == 0)) begin
                bus.wr_valid = 1'b0;
                gapped = 1;
            end else begin
                bus.wr_valid = 1'b1;
            end
            bus.wr_data = exp_wd[i];
            @(negedge clk);
            take = bus.wr_valid && bus.wr_ready;
            to_drive();
            if (take) i++;
            t++;
        end
        bus.wr_valid = 1'b0;
        chk("wr_beats_sent", 64'(i), 64'(exp_wd.size()));
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int t = 0;
        while (rsp_d.size() < n && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("rsp_count", 64'(rsp_d.size()), 64'(n));
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        repeat (2) @(negedge clk);
        #1;
        while (busy && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("idle_reached", 64'(busy), 0);
        chk("idle_cmd_ready", 64'(bus.cmd_ready), 1);
        to_drive();
    endtask

    task automatic check_writes(input logic [AW-1:0] base, input int beats);
        logic [AW-1:0] a;
        chk("wr_count", 64'(wr_a.size()), 64'(beats));
        for (int i = 0; i < beats && i < wr_a.size(); i++) begin
            a = base + AW'(i);
            chk("wr_addr", 64'(wr_a[i]), 64'(a));
            chk("wr_data", 64'(wr_d[i]), 64'(exp_wd[i]));
        end
    endtask

    task automatic check_reads(input logic [AW-1:0] base, input int beats);
        logic [AW-1:0] a;
        chk("rd_issue_count", 64'(iss_a.size()), 64'(beats));
        chk("rd_rsp_count", 64'(rsp_d.size()), 64'(beats));
        for (int i = 0; i < beats; i++) begin
            a = base + AW'(i);
            if (i < iss_a.size()) begin
                chk("rd_issue_addr", 64'(iss_a[i]), 64'(a));
                chk("rd_issue_last", 64'(iss_l[i]), 64'(i == beats - 1));
            end
            if (i < rsp_d.size()) begin
                chk("rsp_data", 64'(rsp_d[i]), 64'(a));
                chk("rsp_last", 64'(rsp_l[i]), 64'(i == beats - 1));
            end
        end
        chk("rsp_fifo_empty", 64'(bus.rsp_valid), 0);
        chk("pipe_align", 64'(pipe_errs), 0);
    endtask

    task automatic run_write(input logic [AW-1:0] base, input int len, input int gap_at, input bit rnd);
        clear_logs();
        exp_wd.delete();
        for (int i = 0; i <= len; i++) exp_wd.push_back(rnd ? DW'($urandom) : DW'(32'hA0 + i));
        send_cmd(1'b1, base, LW'(len));
        push_beats(gap_at, rnd);
        wait_idle(50);
        check_writes(base, len + 1);
    endtask

    task automatic run_read(input logic [AW-1:0] base, input int len, input int mode);
        clear_logs();
        rdy_mode = mode;
        send_cmd(1'b0, base, LW'(len));
        wait_rsp(len + 1, 40 * (len + 1) + 100);
        wait_idle(100);
        check_reads(base, len + 1);
        rdy_mode = 0;
    endtask

    initial begin
        int t;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 1);
        chk("rst_wr_ready", 64'(bus.wr_ready), 0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_err", 64'(err_spurious), 0);
        chk("rst_wren", 64'(bus.lb_wren), 0);
        chk("rst_rden16", 64'(bus.lb_rden16), 0);
        chk("rst_raddr16_zero", 64'(bus.lb_raddr16 == '0), 1);
        to_drive();

        // four-beat write with one stalled beat
        run_write(24'h010000, 3, 2, 1'b0);
        if (wr_c.size() >= 4) begin
            chk("wr_gap_b0b1", 64'(wr_c[1] - wr_c[0]), 1);
            chk("wr_gap_b1b2", 64'(wr_c[2] - wr_c[1]), 2);
            chk("wr_gap_b2b3", 64'(wr_c[3] - wr_c[2]), 1);
        end else begin
            chk("wr_gap_beats_seen", 64'(wr_c.size()), 4);
        end

        run_read(24'h040000, 7, 0);
        run_read(24'h000123, 0, 0);

        // credit stall with consumer blocked
        clear_logs();
        rdy_mode = 2;
        send_cmd(1'b0, 24'h100000, 63);
        repeat (80) @(negedge clk);
        #1;
        chk("stall_issue_count", 64'(iss_a.size()), 64'(RD));
        chk("stall_rsp_valid", 64'(bus.rsp_valid), 1);
        chk("stall_busy", 64'(busy), 1);
        rdy_mode = 0;
        wait_rsp(64, 2000);
        wait_idle(100);
        check_reads(24'h100000, 64);

        run_read(24'hFFFFFE, 3, 0);
        run_write(24'hFFFFFF, 2, -1, 1'b0);

        // reset mid-burst
        clear_logs();
        send_cmd(1'b0, 24'h200000, 7);
        t = 0;
        while (iss_a.size() < 3 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("pre_reset_issues", 64'(iss_a.size()), 3);
        to_drive();
        reset = 1'b1;
        to_drive();
        to_drive();
        reset = 1'b0;
        clear_logs();
        @(negedge clk);
        #1;
        chk("post_rst_rden", 64'(bus.lb_rden), 0);
        chk("post_rst_rsp_valid", 64'(bus.rsp_valid), 0);
        chk("post_rst_busy", 64'(busy), 0);
        to_drive();
        inj_rvalid = 1'b1;
        to_drive();
        inj_rvalid = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("post_rst_no_issue", 64'(iss_a.size()), 0);
        chk("post_rst_no_rsp", 64'(rsp_d.size()), 0);
        chk("post_rst_err_guard", 64'(err_spurious), 0);
        chk("post_rst_fifo_empty", 64'(bus.rsp_valid), 0);
        to_drive();
        run_read(24'h200010, 7, 1);

        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 1)
                run_write(AW'($urandom), $urandom_range(0, 20), -1, 1'b1);
            else
                run_read(AW'($urandom), $urandom_range(0, 40), 1);
        end

        // spurious return while idle
        clear_logs();
        inj_rvalid = 1'b1;
        to_drive();
        inj_rvalid = 1'b0;
        @(negedge clk);
        #1;
        chk("spur_err_set", 64'(err_spurious), 1);
        chk("spur_no_rsp", 64'(bus.rsp_valid), 0);
        repeat (10) @(negedge clk);
        #1;
        chk("spur_err_sticky", 64'(err_spurious), 1);
        chk("spur_rsp_count", 64'(rsp_d.size()), 0);
        to_drive();
        reset = 1'b1;
        to_drive();
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("spur_err_cleared", 64'(err_spurious), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
